dap_sclk_burst_gen: RTL and testbench

//  Next-gen DAP probe clock generator, single clk domain (clock enables, no sclk_in).

---
 rtl/dap_sclk_pkg.sv | 22 ++
 rtl/dap_pulse_delay.sv | 27 ++
 rtl/dap_sclk_burst_gen.sv | 201 ++++++++++++++++++++
 tb/tb_dap_sclk_burst_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dap_sclk_pkg.sv
// Shared definitions for the DAP SCLK burst generator: register map, bit indices, FSM states.
package dap_sclk_pkg;

  localparam logic [3:0] RegCr     = 4'h0;
  localparam logic [3:0] RegTiming = 4'h4;
  localparam logic [3:0] RegBurst  = 4'h8;
  localparam logic [3:0] RegSr     = 4'hC;

  localparam int unsigned CrCen       = 0;
  localparam int unsigned CrCpol      = 1;
  localparam int unsigned CrMode      = 2;
  localparam int unsigned CrStart     = 8;
  localparam int unsigned SrBusy      = 0;
  localparam int unsigned SrDone      = 1;
  localparam int unsigned TimDelayLsb = 16;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StHalfA = 2'd1;
  localparam state_t StHalfB = 2'd2;

endpackage

// File: rtl/dap_pulse_delay.sv
// Delays a single-cycle pulse by a selectable number of clk cycles (tap 0 = no delay).
module dap_pulse_delay #(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     clear_i,
  input  logic                     pulse_i,
  input  logic [$clog2(Depth)-1:0] tap_i,
  output logic                     pulse_o
);

  logic [Depth-2:0] shift_q;
  logic [Depth-1:0] taps;

  assign taps = {shift_q, pulse_i};

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= taps[Depth-2:0];
    end
  end

  assign pulse_o = taps[tap_i];

endmodule

// File: rtl/dap_sclk_burst_gen.sv
// DAP probe SCLK generator: AHB register file, half-period divider, free-run/burst FSM and
// launch/sample reference pulses, all in the clk domain.
module dap_sclk_burst_gen
  import dap_sclk_pkg::*;
#(
  parameter int unsigned          ADDRWIDTH   = 12,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned          DIV_WIDTH   = 16,
  parameter int unsigned          CNT_WIDTH   = 16,
  parameter int unsigned          DELAY_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ahb_write_en,
  input  logic                 ahb_read_en,
  input  logic [ADDRWIDTH-1:0] ahb_addr,
  input  logic [31:0]          ahb_wdata,
  input  logic [3:0]           ahb_byte_strobe,
  output logic [31:0]          ahb_rdata,
  input  logic                 ext_start,
  output logic                 sclk_out,
  output logic                 sclk_pulse,
  output logic                 sclk_delay_pulse,
  output logic                 busy,
  output logic                 done_irq
);

  localparam int unsigned DelayW = $clog2(DELAY_DEPTH);

  logic                 cen_q, cen_d, cpol_q, cpol_d, mode_q, mode_d, done_q, done_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [DelayW-1:0]    delay_q, delay_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d, rem_q, rem_d;
  state_t               state_q, state_d;

  // Offset with a borrow bit so addresses below BASE_ADDR never alias into the block.
  logic [ADDRWIDTH:0] offset;
  logic               in_blk;
  logic [3:0]         reg_sel;
  logic               sel_cr, sel_tim, sel_burst, sel_sr;

  assign offset    = {1'b0, ahb_addr} - {1'b0, BASE_ADDR};
  assign in_blk    = !offset[ADDRWIDTH] && (offset[ADDRWIDTH-1:4] == '0);
  assign reg_sel   = {offset[3:2], 2'b00};
  assign sel_cr    = in_blk && (reg_sel == RegCr);
  assign sel_tim   = in_blk && (reg_sel == RegTiming);
  assign sel_burst = in_blk && (reg_sel == RegBurst);
  assign sel_sr    = in_blk && (reg_sel == RegSr);

  logic [31:0] cr_img, tim_img, burst_img, sr_img, wmask, cr_new, tim_new, burst_new;
  logic        wr_cr, wr_tim, wr_burst, start_wr, done_clr, start, stop, finish;
  logic        unused_bits;

  always_comb begin
    cr_img                            = '0;
    cr_img[CrCen]                     = cen_q;
    cr_img[CrCpol]                    = cpol_q;
    cr_img[CrMode]                    = mode_q;
    tim_img                           = '0;
    tim_img[DIV_WIDTH-1:0]            = div_q;
    tim_img[TimDelayLsb +: DelayW]    = delay_q;
    burst_img                         = '0;
    burst_img[CNT_WIDTH-1:0]          = burst_q;
    sr_img                            = '0;
    sr_img[SrBusy]                    = busy;
    sr_img[SrDone]                    = done_q;
  end

  assign wmask     = {{8{ahb_byte_strobe[3]}}, {8{ahb_byte_strobe[2]}},
                      {8{ahb_byte_strobe[1]}}, {8{ahb_byte_strobe[0]}}};
  assign cr_new    = (cr_img & ~wmask) | (ahb_wdata & wmask);
  assign tim_new   = (tim_img & ~wmask) | (ahb_wdata & wmask);
  assign burst_new = (burst_img & ~wmask) | (ahb_wdata & wmask);

  assign wr_cr     = ahb_write_en && sel_cr;
  assign wr_tim    = ahb_write_en && sel_tim && !busy;
  assign wr_burst  = ahb_write_en && sel_burst && !busy;
  assign start_wr  = wr_cr && ahb_byte_strobe[1] && ahb_wdata[CrStart];
  assign done_clr  = ahb_write_en && sel_sr && ahb_byte_strobe[0] && ahb_wdata[SrDone];

  assign unused_bits = ^{cr_new, tim_new, burst_new, offset[1:0]};

  always_comb begin
    cen_d   = wr_cr ? cr_new[CrCen] : cen_q;
    cpol_d  = (wr_cr && !busy) ? cr_new[CrCpol] : cpol_q;
    mode_d  = (wr_cr && !busy) ? cr_new[CrMode] : mode_q;
    div_d   = wr_tim ? tim_new[DIV_WIDTH-1:0] : div_q;
    delay_d = wr_tim ? tim_new[TimDelayLsb +: DelayW] : delay_q;
    burst_d = wr_burst ? burst_new[CNT_WIDTH-1:0] : burst_q;
  end

  assign busy  = (state_q != StIdle);
  assign start = !busy && cen_d && (mode_d ? (start_wr || ext_start) : !cen_q);
  assign stop  = busy && !cen_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    finish  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHalfA;
          cnt_d   = '0;
          rem_d   = burst_q;
        end
      end
      StHalfA: begin
        if (mode_q && (rem_q == '0)) begin
          state_d = StIdle;
          finish  = 1'b1;
        end else if (cnt_q == div_q) begin
          state_d = StHalfB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      StHalfB: begin
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          state_d = StHalfA;
          if (mode_q) begin
            rem_d = rem_q - CNT_WIDTH'(1);
            if (rem_q == CNT_WIDTH'(1)) begin
              state_d = StIdle;
              finish  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Disabling mid-run aborts without reporting completion.
    if (stop) begin
      state_d = StIdle;
      cnt_d   = '0;
      finish  = 1'b0;
    end
  end

  always_comb begin
    done_d = done_q;
    if (done_clr) done_d = 1'b0;
    if (finish)   done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cen_q   <= 1'b0;
      cpol_q  <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      delay_q <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      state_q <= StIdle;
    end else begin
      cen_q   <= cen_d;
      cpol_q  <= cpol_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      div_q   <= div_d;
      delay_q <= delay_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      state_q <= state_d;
    end
  end

  assign sclk_out   = cpol_q ^ (state_q == StHalfB);
  assign sclk_pulse = (state_q == StHalfA) && (cnt_q == div_q) && !(mode_q && (rem_q == '0));
  assign done_irq   = done_q;

  dap_pulse_delay #(
    .Depth (DELAY_DEPTH)
  ) u_pulse_delay (
    .clk_i   (clk),
    .clear_i (reset || stop),
    .pulse_i (sclk_pulse),
    .tap_i   (delay_q),
    .pulse_o (sclk_delay_pulse)
  );

  always_comb begin
    ahb_rdata = '0;
    if (ahb_read_en) begin
      if (sel_cr)         ahb_rdata = cr_img;
      else if (sel_tim)   ahb_rdata = tim_img;
      else if (sel_burst) ahb_rdata = burst_img;
      else if (sel_sr)    ahb_rdata = sr_img;
    end
  end

endmodule

// File: tb/tb_dap_sclk_burst_gen.sv
// Scoreboard bench for dap_sclk_burst_gen: expected run summaries and register reads are queued
// by the stimulus and checked by an independent monitor.
module tb_dap_sclk_burst_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ahb_write_en = 1'b0;
  logic        ahb_read_en = 1'b0;
  logic [11:0] ahb_addr = '0;
  logic [31:0] ahb_wdata = '0;
  logic [3:0]  ahb_byte_strobe = '0;
  logic [31:0] ahb_rdata;
  logic        ext_start = 1'b0;
  logic        sclk_out, sclk_pulse, sclk_delay_pulse, busy, done_irq;

  always #5 clk = ~clk;

  dap_sclk_burst_gen dut (
    .clk              (clk),
    .reset            (reset),
    .ahb_write_en     (ahb_write_en),
    .ahb_read_en      (ahb_read_en),
    .ahb_addr         (ahb_addr),
    .ahb_wdata        (ahb_wdata),
    .ahb_byte_strobe  (ahb_byte_strobe),
    .ahb_rdata        (ahb_rdata),
    .ext_start        (ext_start),
    .sclk_out         (sclk_out),
    .sclk_pulse       (sclk_pulse),
    .sclk_delay_pulse (sclk_delay_pulse),
    .busy             (busy),
    .done_irq         (done_irq)
  );

  typedef struct {
    string tag;
    int idle, lat, edges, pulses, dpulses, busy_cyc, dly, sclk_end, done_end;
  } run_t;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } rd_t;

  run_t exp_runs[$];
  rd_t  exp_reads[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    ahb_write_en = 1'b1; ahb_addr = a; ahb_wdata = d; ahb_byte_strobe = be;
    @(posedge clk); #1;
    ahb_write_en = 1'b0; ahb_byte_strobe = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd_t r;
    @(posedge clk); #1;
    r.tag = tag; r.data = exp;
    exp_reads.push_back(r);
    ahb_read_en = 1'b1; ahb_addr = a;
    @(posedge clk); #1;
    ahb_read_en = 1'b0;
  endtask

  task automatic push_run(input string tag, input int idle, input int lat, input int edges,
                          input int pulses, input int dp, input int bc, input int dly,
                          input int se, input int de);
    run_t r;
    r.tag = tag; r.idle = idle; r.lat = lat; r.edges = edges; r.pulses = pulses;
    r.dpulses = dp; r.busy_cyc = bc; r.dly = dly; r.sclk_end = se; r.done_end = de;
    exp_runs.push_back(r);
  endtask

  task automatic wait_runs(input int budget);
    int n = 0;
    while (exp_runs.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_runs.size() != 0) begin
      check("run_timeout", exp_runs.size(), 0);
      exp_runs.delete();
    end
  endtask

  // Monitor: measures each busy window and checks register reads.
  initial begin
    run_t r;
    rd_t  q;
    int   cyc = 0, m_idle = 0, m_lat = 0, m_edges = 0, m_pulses = 0, m_dp = 0, m_busy = 0;
    int   m_fp = 0, m_fd = 0, dly;
    logic busy_prev = 1'b0, prev_sclk = 1'b0;
    wait (reset == 1'b0);
    forever begin
      @(negedge clk);
      cyc++;
      if (ahb_read_en) begin
        if (exp_reads.size() == 0) begin
          check("unexpected_read", 1, 0);
        end else begin
          q = exp_reads.pop_front();
          check32(q.tag, ahb_rdata, q.data);
        end
      end
      if (busy && !busy_prev) begin
        m_idle = int'(sclk_out); m_lat = -1; m_edges = 0; m_pulses = 0; m_dp = 0;
        m_busy = 0; m_fp = -1; m_fd = -1; prev_sclk = sclk_out;
      end
      if (busy) begin
        m_busy++;
        if (sclk_out != prev_sclk && int'(sclk_out) != m_idle) begin
          m_edges++;
          if (m_lat < 0) m_lat = m_busy - 1;
        end
        if (sclk_pulse) begin
          m_pulses++;
          if (m_fp < 0) m_fp = cyc;
        end
        if (sclk_delay_pulse) begin
          m_dp++;
          if (m_fd < 0) m_fd = cyc;
        end
        prev_sclk = sclk_out;
      end
      if (!busy && busy_prev) begin
        if (exp_runs.size() == 0) begin
          check("unexpected_run", 1, 0);
        end else begin
          r = exp_runs.pop_front();
          dly = (m_fp < 0 || m_fd < 0) ? -1 : m_fd - m_fp;
          check({r.tag, ".idle"}, m_idle, r.idle);
          check({r.tag, ".lat"}, m_lat, r.lat);
          check({r.tag, ".edges"}, m_edges, r.edges);
          check({r.tag, ".pulses"}, m_pulses, r.pulses);
          check({r.tag, ".dpulses"}, m_dp, r.dpulses);
          check({r.tag, ".busy"}, m_busy, r.busy_cyc);
          check({r.tag, ".dly"}, dly, r.dly);
          check({r.tag, ".sclk_end"}, int'(sclk_out), r.sclk_end);
          check({r.tag, ".done"}, int'(done_irq), r.done_end);
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd("rst.cr", 12'h000, 32'h0);
    rd("rst.sr", 12'h00C, 32'h0);

    // 1: burst of 4, DIV=0 -> 1-cycle halves
    wr(12'h004, 32'h0, 4'hF);
    wr(12'h008, 32'd4, 4'hF);
    push_run("t1", 0, 1, 4, 4, 4, 8, 0, 0, 1);
    wr(12'h000, 32'h105, 4'hF);
    wait_runs(200);
    rd("t1.sr", 12'h00C, 32'h2);
    wr(12'h00C, 32'h2, 4'hF);
    rd("t1.sr_clr", 12'h00C, 32'h0);

    // 2: CPOL=1, DIV=2, DELAY=3, hardware trigger
    wr(12'h004, 32'h0003_0002, 4'hF);
    wr(12'h008, 32'd2, 4'hF);
    wr(12'h000, 32'h7, 4'hF);
    rd("t2.tim", 12'h004, 32'h0003_0002);
    push_run("t2", 1, 3, 2, 2, 2, 12, 3, 1, 1);
    @(posedge clk); #1 ext_start = 1'b1;
    @(posedge clk); #1 ext_start = 1'b0;
    wait_runs(200);
    wr(12'h00C, 32'h2, 4'hF);

    // 3: free-run DIV=1 for 40 cycles; byte-lane write and unmapped read
    wr(12'h000, 32'h0, 4'hF);
    wr(12'h004, 32'h0, 4'hF);
    wr(12'h004, 32'hFFFF_FF01, 4'b0001);
    rd("t3.tim_be", 12'h004, 32'h1);
    rd("t3.unmapped", 12'h010, 32'h0);
    push_run("t3", 0, 2, 10, 10, 10, 40, 0, 0, 0);
    wr(12'h000, 32'h1, 4'hF);
    repeat (38) @(posedge clk);
    wr(12'h000, 32'h0, 4'hF);
    wait_runs(100);

    // 4: BURST=0 -> one busy cycle, no edges
    wr(12'h008, 32'd0, 4'hF);
    push_run("t4", 0, -1, 0, 0, 0, 1, -1, 0, 1);
    wr(12'h000, 32'h105, 4'hF);
    wait_runs(50);
    rd("t4.sr", 12'h00C, 32'h2);
    wr(12'h00C, 32'h2, 4'hF);
    rd("t4.sr_clr", 12'h00C, 32'h0);

    // 5: writes during a burst are ignored
    wr(12'h004, 32'h1, 4'hF);
    wr(12'h008, 32'd6, 4'hF);
    push_run("t5", 0, 2, 6, 6, 6, 24, 0, 0, 1);
    wr(12'h000, 32'h105, 4'hF);
    wr(12'h004, 32'h5, 4'hF);
    wr(12'h000, 32'h105, 4'hF);
    rd("t5.tim", 12'h004, 32'h1);
    rd("t5.burst", 12'h008, 32'd6);
    rd("t5.sr_busy", 12'h00C, 32'h1);
    wait_runs(200);
    wr(12'h00C, 32'h2, 4'hF);

    // 6: reset in period 2 of 8, then a full run
    wr(12'h008, 32'd8, 4'hF);
    push_run("t6a", 0, 2, 1, 2, 2, 6, 0, 0, 0);
    wr(12'h000, 32'h105, 4'hF);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_runs(50);
    rd("t6.cr", 12'h000, 32'h0);
    rd("t6.tim", 12'h004, 32'h0);
    rd("t6.burst", 12'h008, 32'h0);
    rd("t6.sr", 12'h00C, 32'h0);
    wr(12'h004, 32'h1, 4'hF);
    wr(12'h008, 32'd8, 4'hF);
    push_run("t6b", 0, 2, 8, 8, 8, 32, 0, 0, 1);
    wr(12'h000, 32'h105, 4'hF);
    wait_runs(200);

    @(negedge clk);
    if (exp_reads.size() != 0) check("reads_pending", exp_reads.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
